// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes processor loads/stores onto data RAM, transmit FIFO, status, timer and button input. Rev 1.0
// Optional free-running timer built only when MMIO_TIMER_EN is defined.
`default_nettype none

module mmio_bridge #(
  parameter int FIFO_DEPTH = 8,
  parameter int RAM_WORDS  = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  buttons
);

  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  c_depth     = 7'(FIFO_DEPTH);
  localparam logic [31:0] c_addr_tx   = 32'h0000_F000;
  localparam logic [31:0] c_addr_stat = 32'h0000_F001;
  localparam logic [31:0] c_addr_tmr  = 32'h0000_F002;
  localparam logic [31:0] c_addr_in   = 32'h0000_F003;

  logic             w_sel_ram;
  logic             w_sel_tx;
  logic             w_sel_stat;
  logic             w_sel_tmr;
  logic             w_sel_in;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_store_tx;
  logic [31:0]      w_timer_val;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [6:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       sync1_q;
  logic [7:0]       sync2_q;
  logic [7:0]       fifo_q [FIFO_DEPTH];

  assign w_sel_ram  = (address_dmem < 32'(RAM_WORDS));
  assign w_sel_tx   = (address_dmem == c_addr_tx);
  assign w_sel_stat = (address_dmem == c_addr_stat);
  assign w_sel_tmr  = (address_dmem == c_addr_tmr);
  assign w_sel_in   = (address_dmem == c_addr_in);

  assign ram_addr   = address_dmem[11:0];
  assign ram_data   = data;
  assign ram_wren   = wren & w_sel_ram & reset;

  assign w_full     = (count_q == c_depth);
  assign w_empty    = (count_q == 7'd0);
  assign tx_valid   = ~w_empty;
  assign tx_data    = w_empty ? 8'h00 : fifo_q[rd_ptr_q];

  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign w_pop      = tx_valid & tx_ready;
  assign w_store_tx = wren & w_sel_tx;
  assign w_push     = w_store_tx & (~w_full | w_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
    if (w_store_tx && !w_push) begin
      ovf_d = 1'b1;
    end
    if (wren && w_sel_stat && data[15]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 7'd0;
      ovf_q    <= 1'b0;
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sync1_q  <= buttons;
      sync2_q  <= sync1_q;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (reset && w_push) begin
      fifo_q[wr_ptr_q] <= data[7:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic        w_store_tmr;
  logic [31:0] timer_q, timer_d;

  assign w_store_tmr = wren & w_sel_tmr;

  // The store clears the count in its own cycle, so the next cycle already reads 1.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (w_store_tmr) begin
      timer_d = 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      timer_q <= 32'd0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign w_timer_val = timer_q;
`else
  assign w_timer_val = 32'd0;
`endif

  always_comb begin
    q_dmem = 32'd0;
    if (w_sel_ram) begin
      q_dmem = ram_q;
    end else if (w_sel_stat) begin
      q_dmem = {16'b0, ovf_q, w_full, w_empty, 6'b0, count_q};
    end else if (w_sel_tmr) begin
      q_dmem = w_timer_val;
    end else if (w_sel_in) begin
      q_dmem = {24'b0, sync2_q};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed self-checking bench for mmio_bridge. Rev 1.0
`default_nettype none

module tb_mmio_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  buttons;

  int checks = 0;
  int errors = 0;
  int wren_cycles = 0;

  logic [31:0] ram_mem [4096];

  always #5 clock = ~clock;

  mmio_bridge #(.FIFO_DEPTH(8), .RAM_WORDS(4096)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .buttons(buttons)
  );

  assign ram_q = ram_mem[ram_addr];

  always @(posedge clock) begin
    if (ram_wren === 1'b1) begin
      ram_mem[ram_addr] <= ram_data;
      wren_cycles++;
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    address_dmem = a;
    data = d;
    wren = 1'b1;
    @(posedge clock);
    #1;
    wren = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    address_dmem = 32'd5;
    data = 32'h1234_5678;
    wren = 1'b1;
    #1;
    checks++;
    if (ram_wren !== 1'b0) begin
      errors++; $display("FAIL ram_wren_in_reset: got %b, expected 0", ram_wren);
    end
    @(negedge clock);
    wren = 1'b0;
    reset = 1'b1;
    address_dmem = 32'h0000_F001;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx: got valid %b data %h, expected 0 00", tx_valid, tx_data);
    end
    checks++;
    if (q_dmem !== 32'h0000_2000) begin
      errors++; $display("FAIL reset_status: got %h, expected 00002000", q_dmem);
    end
    address_dmem = 32'h0000_F003;
    #1;
    checks++;
    if (q_dmem !== 32'h0) begin
      errors++; $display("FAIL reset_input: got %h, expected 00000000", q_dmem);
    end
  endtask

  task automatic test_ram();
    wren_cycles = 0;
    @(negedge clock);
    address_dmem = 32'd5;
    data = 32'hDEAD_BEEF;
    wren = 1'b1;
    #1;
    checks++;
    if (ram_wren !== 1'b1 || ram_addr !== 12'd5 || ram_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_store: got wren %b addr %h data %h, expected 1 005 deadbeef", ram_wren, ram_addr, ram_data);
    end
    @(posedge clock);
    #1;
    wren = 1'b0;
    #1;
    checks++;
    if (q_dmem !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_load: got %h, expected deadbeef", q_dmem);
    end
    @(posedge clock);
    #1;
    checks++;
    if (wren_cycles != 1) begin
      errors++; $display("FAIL ram_wren_cycles: got %0d, expected 1", wren_cycles);
    end
    // First address past the RAM is unmapped: no write, reads zero.
    address_dmem = 32'h0000_1000;
    data = 32'hCAFE_F00D;
    wren = 1'b1;
    #1;
    checks++;
    if (ram_wren !== 1'b0 || q_dmem !== 32'h0) begin
      errors++; $display("FAIL unmapped_store: got wren %b q %h, expected 0 00000000", ram_wren, q_dmem);
    end
    address_dmem = 32'h0000_0FFF;
    #1;
    checks++;
    if (ram_wren !== 1'b1) begin
      errors++; $display("FAIL ram_top_word: got wren %b, expected 1", ram_wren);
    end
    wren = 1'b0;
    address_dmem = 32'h0000_F000;
    #1;
    checks++;
    if (q_dmem !== 32'h0) begin
      errors++; $display("FAIL txdata_read: got %h, expected 00000000", q_dmem);
    end
  endtask

  task automatic test_fill_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      store(32'h0000_F000, 32'h0000_0041 + 32'(i));
      if (i == 0) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
          errors++; $display("FAIL first_push: got valid %b data %h, expected 1 41", tx_valid, tx_data);
        end
      end
    end
    store(32'h0000_F000, 32'h0000_0049);
    address_dmem = 32'h0000_F001;
    #1;
    checks++;
    if (q_dmem !== 32'h0000_C008) begin
      errors++; $display("FAIL status_overflow: got %h, expected 0000c008", q_dmem);
    end
  endtask

  task automatic test_drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== (8'h41 + 8'(i))) begin
        errors++; $display("FAIL drain_%0d: got valid %b data %h, expected 1 %h", i, tx_valid, tx_data, 8'h41 + 8'(i));
      end
      @(posedge clock);
    end
    #1;
    checks++;
    if (tx_valid !== 1'b0 || q_dmem !== 32'h0000_A000) begin
      errors++; $display("FAIL drain_end: got valid %b status %h, expected 0 0000a000", tx_valid, q_dmem);
    end
    tx_ready = 1'b0;
    store(32'h0000_F001, 32'h0000_8000);
    address_dmem = 32'h0000_F001;
    #1;
    checks++;
    if (q_dmem !== 32'h0000_2000) begin
      errors++; $display("FAIL overflow_clear: got %h, expected 00002000", q_dmem);
    end
  endtask

  task automatic test_push_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      store(32'h0000_F000, 32'h0000_0060 + 32'(i));
    end
    @(negedge clock);
    address_dmem = 32'h0000_F000;
    data = 32'h0000_0050;
    wren = 1'b1;
    tx_ready = 1'b1;
    @(posedge clock);
    #1;
    wren = 1'b0;
    tx_ready = 1'b0;
    address_dmem = 32'h0000_F001;
    #1;
    checks++;
    if (q_dmem !== 32'h0000_4008 || tx_data !== 8'h61) begin
      errors++; $display("FAIL push_pop_full: got status %h head %h, expected 00004008 61", q_dmem, tx_data);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp;
      exp = (i < 7) ? (8'h61 + 8'(i)) : 8'h50;
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        errors++; $display("FAIL push_pop_drain_%0d: got valid %b data %h, expected 1 %h", i, tx_valid, tx_data, exp);
      end
      @(posedge clock);
    end
    #1;
    checks++;
    if (tx_valid !== 1'b0 || q_dmem !== 32'h0000_2000) begin
      errors++; $display("FAIL push_pop_end: got valid %b status %h, expected 0 00002000", tx_valid, q_dmem);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_timer();
    logic [31:0] exp;
`ifdef MMIO_TIMER_EN
    exp = 32'd10;
`else
    exp = 32'd0;
`endif
    store(32'h0000_F002, 32'hFFFF_FFFF);
    repeat (9) @(posedge clock);
    #1;
    address_dmem = 32'h0000_F002;
    #1;
    checks++;
    if (q_dmem !== exp) begin
      errors++; $display("FAIL timer_read: got %h, expected %h", q_dmem, exp);
    end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h0000_F000, 32'h0000_0031 + 32'(i));
    end
    address_dmem = 32'h0000_F001;
    #1;
    checks++;
    if (q_dmem !== 32'h0000_0003) begin
      errors++; $display("FAIL three_queued: got %h, expected 00000003", q_dmem);
    end
    @(negedge clock);
    reset = 1'b0;
    address_dmem = 32'h0000_F000;
    data = 32'h0000_0077;
    wren = 1'b1;
    tx_ready = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    wren = 1'b0;
    tx_ready = 1'b0;
    address_dmem = 32'h0000_F001;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || q_dmem !== 32'h0000_2000) begin
      errors++; $display("FAIL reset_mid: got valid %b status %h, expected 0 00002000", tx_valid, q_dmem);
    end
  endtask

  task automatic test_input_sync();
    @(negedge clock);
    buttons = 8'h5A;
    address_dmem = 32'h0000_F003;
    #1;
    checks++;
    if (q_dmem !== 32'h0) begin
      errors++; $display("FAIL sync_cycle0: got %h, expected 00000000", q_dmem);
    end
    @(posedge clock);
    #1;
    checks++;
    if (q_dmem !== 32'h0) begin
      errors++; $display("FAIL sync_cycle1: got %h, expected 00000000", q_dmem);
    end
    @(posedge clock);
    #1;
    checks++;
    if (q_dmem !== 32'h0000_005A) begin
      errors++; $display("FAIL sync_cycle2: got %h, expected 0000005a", q_dmem);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 32'h0;
    end
    reset = 1'b0;
    address_dmem = 32'h0;
    data = 32'h0;
    wren = 1'b0;
    tx_ready = 1'b0;
    buttons = 8'h00;
    test_reset();
    test_ram();
    test_fill_overflow();
    test_drain();
    test_push_pop();
    test_timer();
    test_reset_mid();
    test_input_sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8 (power of two, 2..64), the number of entries in the transmit FIFO.
REQ-002 SHALL have parameter RAM_WORDS, default 4096, the number of data-RAM words, mapped at word addresses 0..RAM_WORDS-1.
REQ-003 clock  input  1  master clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 address_dmem  input  32  word address from the processor memory stage.
REQ-006 data  input  32  processor store data.
REQ-007 wren  input  1  processor store enable.
REQ-008 q_dmem  output  32  load data returned to the processor.
REQ-009 ram_addr  output  12  data-RAM address, equal to address_dmem[11:0].
REQ-010 ram_data  output  32  data-RAM write data, equal to data.
REQ-011 ram_wren  output  1  data-RAM write enable.
REQ-012 ram_q  input  32  data-RAM read data.
REQ-013 tx_data  output  8  head of the transmit FIFO.
REQ-014 tx_valid  output  1  transmit FIFO is non-empty.
REQ-015 tx_ready  input  1  downstream consumer accepts tx_data this cycle.
REQ-016 buttons  input  8  asynchronous driver-control inputs.

Function
REQ-017 SHALL decode addresses combinationally: RAM for 0..RAM_WORDS-1; TX_DATA at 0xF000; STATUS at 0xF001; TIMER at 0xF002; INPUT at 0xF003; all other addresses are unmapped.
REQ-018 SHALL drive ram_wren = wren AND the address is in RAM range; stores to any other address SHALL never reach the RAM.
REQ-019 SHALL drive q_dmem combinationally in the same cycle as address_dmem, with no added latency, as follows.
- RAM range: ram_q.
- TX_DATA: 0.
- STATUS: {16'b0, overflow, full, empty, 6'b0, count[6:0]}, with bit 15 = overflow, bit 14 = full, bit 13 = empty.
- TIMER: the timer value.
- INPUT: {24'b0, synchronized buttons}.
- Unmapped: 0.
REQ-020 A store to TX_DATA SHALL push data[7:0] at the rising edge when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-021 A store to TX_DATA while full with no simultaneous pop SHALL be dropped and SHALL set the sticky overflow bit.
REQ-022 A pop SHALL occur when tx_valid AND tx_ready; tx_data SHALL present the next entry in the following cycle.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; on an empty FIFO, tx_valid SHALL assert in the cycle after the push.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH, full = (count == FIFO_DEPTH), empty = (count == 0).
REQ-025 A store to STATUS with data[15]=1 SHALL clear overflow; other STATUS bits are read-only.
REQ-026 The timer SHALL be a 32-bit free-running counter incrementing by 1 per cycle and wrapping 0xFFFFFFFF -> 0.
REQ-027 A store to TIMER SHALL load the timer with 0, and the timer SHALL read 1 the following cycle.
REQ-028 buttons SHALL pass through a two-flop synchronizer, so a change is visible at INPUT exactly 2 cycles after it is sampled.
REQ-029 Loads SHALL have no side effects on any state.

Reset
REQ-030 While reset=0 at a rising edge, the block SHALL clear FIFO pointers, count, overflow, timer and synchronizer flops to 0.
REQ-031 After reset, tx_valid=0 and tx_data=0; STATUS SHALL read 0x00002000 (empty only).
REQ-032 ram_wren SHALL be forced to 0 while reset=0.
REQ-033 A push or pop coincident with reset SHALL be discarded; reset has priority over every other update.

Configuration
REQ-034 Macro MMIO_TIMER_EN SHALL control whether the timer is built.
- Defined: the timer exists per REQ-026/027.
- Undefined: no timer flops are built, TIMER reads 0, and stores to TIMER are ignored.

Verification
REQ-035 The bench SHALL cover a RAM round-trip: store 0xDEADBEEF to address 5, then load address 5 -> q_dmem=0xDEADBEEF, ram_wren high for exactly one cycle.
REQ-036 The bench SHALL cover FIFO fill and overflow: with tx_ready=0, store 0x41..0x48 then 0x49 to 0xF000 -> STATUS=0x0000C008 (overflow|full, count 8), and 0x49 is never emitted.
REQ-037 The bench SHALL cover drain and wrap: tx_ready=1 after REQ-036 -> tx_data emits 0x41..0x48 on consecutive cycles, then tx_valid=0 and STATUS=0x0000A000 (overflow|empty).
REQ-038 The bench SHALL cover push and pop together: while full with tx_ready=1, store 0x50 -> count stays 8 and 0x50 is emitted 8 pops later.
REQ-039 The bench SHALL cover timer behaviour with MMIO_TIMER_EN defined: store to 0xF002, wait 9 cycles, load -> 10. With MMIO_TIMER_EN undefined the same load -> 0.
REQ-040 The bench SHALL cover reset mid-operation and input sync: reset=0 for 1 cycle with 3 entries queued -> tx_valid=0 next cycle. Changing buttons 0x00 -> 0x5A -> INPUT reads 0x5A on the 2nd cycle, not earlier.
